// File: rtl/pipe_red_pkg.sv
// pipe_red_pkg -- shared definitions for the pipelined reduction tree.
//
// Contents:
//   red_mode_e    : reduction mode selected at the top level
//   red_op_e      : operator actually applied by one tree level
//   calc_levels   : number of tree levels, ceil(log_group(width))
//   level_width   : vector width present after a given number of levels
//   level_op      : operator used by a given level for a given mode
//   op_identity   : identity value used to pad a short last group
package pipe_red_pkg;

    typedef enum logic [1:0] {
        RED_OR_AND = 2'd0,
        RED_AND    = 2'd1,
        RED_OR     = 2'd2,
        RED_XOR    = 2'd3
    } red_mode_e;

    typedef enum logic [1:0] {
        OP_OR  = 2'd0,
        OP_AND = 2'd1,
        OP_XOR = 2'd2
    } red_op_e;

    // Width remaining after 'level' reductions; each level divides by
    // the fan-in, rounding up because a short last group still produces
    // one result bit. Bounded loop keeps the function elaboration-friendly.
    function automatic int level_width(input int width, input int group,
                                       input int level);
        int n;
        n = width;
        for (int i = 0; i < 64; i++) begin
            if (i < level) begin
                n = (n + group - 1) / group;
            end
        end
        return n;
    endfunction

    function automatic int calc_levels(input int width, input int group);
        int n;
        int lv;
        n  = width;
        lv = 0;
        for (int i = 0; i < 64; i++) begin
            if (n > 1) begin
                n  = (n + group - 1) / group;
                lv = lv + 1;
            end
        end
        return lv;
    endfunction

    function automatic red_op_e level_op(input red_mode_e mode, input int level);
        red_op_e op;
        op = OP_OR;
        case (mode)
            RED_OR_AND: begin
                if (level == 0) begin
                    op = OP_OR;
                end else begin
                    op = OP_AND;
                end
            end
            RED_AND: op = OP_AND;
            RED_OR:  op = OP_OR;
            RED_XOR: op = OP_XOR;
            default: op = OP_OR;
        endcase
        return op;
    endfunction

    function automatic logic op_identity(input red_op_e op);
        return (op == OP_AND);
    endfunction

endpackage

// File: rtl/pipe_red_tree_stage.sv
// pipe_red_stage -- one registered level of the reduction tree.
//
// Splits up_data into groups of GROUP adjacent bits starting at bit 0,
// pads the short last group with the identity of OP, reduces each group
// to one bit and registers the result together with the valid bit and tag.
// All registers load only when en=1 and clear on synchronous i_rst.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   en                   global advance enable (hold when 0)
//   up_valid/data/tag    item from the previous level (or the input)
//   dn_valid/data/tag    registered item presented to the next level
module pipe_red_stage
    import pipe_red_pkg::*;
#(
    parameter int      IN_W  = 8,
    parameter int      GROUP = 2,
    parameter red_op_e OP    = OP_OR,
    parameter int      TAG_W = 4,
    localparam int     OUT_W = (IN_W + GROUP - 1) / GROUP
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             en,
    input  logic             up_valid,
    input  logic [IN_W-1:0]  up_data,
    input  logic [TAG_W-1:0] up_tag,
    output logic             dn_valid,
    output logic [OUT_W-1:0] dn_data,
    output logic [TAG_W-1:0] dn_tag
);

    localparam int   PAD_W = OUT_W * GROUP;
    localparam logic IDENT = op_identity(OP);

    logic [PAD_W-1:0] padded;
    logic [OUT_W-1:0] reduced;
    logic             acc;

    // Fill everything with the identity first, then overlay the real bits,
    // so the bits beyond IN_W act as neutral padding.
    always_comb begin
        padded            = {PAD_W{IDENT}};
        padded[IN_W-1:0]  = up_data;
    end

    always_comb begin
        reduced = '0;
        acc     = IDENT;
        for (int g = 0; g < OUT_W; g++) begin
            acc = IDENT;
            for (int b = 0; b < GROUP; b++) begin
                case (OP)
                    OP_AND:  acc = acc & padded[g*GROUP + b];
                    OP_XOR:  acc = acc ^ padded[g*GROUP + b];
                    default: acc = acc | padded[g*GROUP + b];
                endcase
            end
            reduced[g] = acc;
        end
    end

    // Bubbles are loaded like items (valid=0), so they are never collapsed.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
            dn_tag   <= '0;
        end else if (en) begin
            dn_valid <= up_valid;
            dn_data  <= reduced;
            dn_tag   <= up_tag;
        end
    end

endmodule

// File: rtl/pipe_red_tree.sv
// pipe_red_tree -- pipelined reduction tree with valid/ready flow control.
//
// Reduces a WIDTH-bit vector to one bit through LEVELS registered levels of
// fan-in GROUP. MODE selects the operator (RED_OR_AND: OR at level 0, AND
// above; otherwise one operator everywhere). A TAG_W sideband tag travels
// with each item.
//
// Handshake: an item moves across an interface on a clock edge where its
// valid and ready are both 1. The whole pipeline advances together on
// en = i_ready | ~o_valid, and o_ready = en; while o_valid=1 and i_ready=0
// every stage holds, so o_data/o_tag stay stable and no input is taken.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_valid, o_ready        upstream handshake
//   i_data [WIDTH], i_tag   item in
//   o_valid, i_ready        downstream handshake
//   o_data, o_tag           result and its tag
//   o_cnt [16]              results accepted downstream (only with
//                           PIPE_RED_CNT_EN defined; wraps, cleared by reset)
module pipe_red_tree
    import pipe_red_pkg::*;
#(
    parameter int        WIDTH = 8,
    parameter int        GROUP = 2,
    parameter red_mode_e MODE  = RED_OR_AND,
    parameter int        TAG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_data,
    output logic [TAG_W-1:0] o_tag
`ifdef PIPE_RED_CNT_EN
    ,
    output logic [15:0]      o_cnt
`endif
);

    localparam int LEVELS = calc_levels(WIDTH, GROUP);

    logic en;

    assign en      = i_ready | ~o_valid;
    assign o_ready = en;

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int      IN_W  = level_width(WIDTH, GROUP, k);
        localparam int      OUT_W = level_width(WIDTH, GROUP, k + 1);
        localparam red_op_e OP    = level_op(MODE, k);

        logic             up_valid;
        logic [IN_W-1:0]  up_data;
        logic [TAG_W-1:0] up_tag;
        logic             dn_valid;
        logic [OUT_W-1:0] dn_data;
        logic [TAG_W-1:0] dn_tag;

        if (k == 0) begin : g_first
            // Loading i_valid under en is exactly "accepted = i_valid & o_ready".
            assign up_valid = i_valid;
            assign up_data  = i_data;
            assign up_tag   = i_tag;
        end else begin : g_next
            assign up_valid = g_lvl[k-1].dn_valid;
            assign up_data  = g_lvl[k-1].dn_data;
            assign up_tag   = g_lvl[k-1].dn_tag;
        end

        pipe_red_stage #(
            .IN_W  (IN_W),
            .GROUP (GROUP),
            .OP    (OP),
            .TAG_W (TAG_W)
        ) u_stage (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .en       (en),
            .up_valid (up_valid),
            .up_data  (up_data),
            .up_tag   (up_tag),
            .dn_valid (dn_valid),
            .dn_data  (dn_data),
            .dn_tag   (dn_tag)
        );
    end

    assign o_valid = g_lvl[LEVELS-1].dn_valid;
    assign o_data  = g_lvl[LEVELS-1].dn_data[0];
    assign o_tag   = g_lvl[LEVELS-1].dn_tag;

`ifdef PIPE_RED_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= 16'd0;
        end else if (o_valid & i_ready) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign o_cnt = cnt_q;
`endif

endmodule
